// File: rtl/mcp_scan_ctrl_if.sv
// ADC transaction engine link between the scan scheduler (master) and the
// SPI conversion engine (slave).
interface mcp_scan_ctrl_if #(
    parameter int unsigned CW     = 3,
    parameter int unsigned DATA_W = 10
);
    logic              adc_start;
    logic [CW-1:0]     adc_ch;
    logic              adc_sgl;
    logic              adc_busy;
    logic              adc_done;
    logic [DATA_W-1:0] adc_data;

    modport master (
        output adc_start, adc_ch, adc_sgl,
        input  adc_busy, adc_done, adc_data
    );

    modport slave (
        input  adc_start, adc_ch, adc_sgl,
        output adc_busy, adc_done, adc_data
    );
endinterface

// File: rtl/mcp_scan_ctrl.sv
// Periodic round-robin ADC scan scheduler with one arbitrated host read slot
// and per-channel over-temperature alarms with hysteresis.
module mcp_scan_ctrl #(
    parameter int unsigned N_CH    = 8,
    parameter int unsigned DATA_W  = 10,
    parameter int unsigned PERIOD  = 50000,
    parameter int unsigned TIMEOUT = 255,
    localparam int unsigned CW     = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   ch_en,
    input  logic [DATA_W-1:0] alarm_hi,
    input  logic [DATA_W-1:0] alarm_lo,
    input  logic              host_req,
    input  logic [CW-1:0]     host_ch,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_data,
    mcp_scan_ctrl_if.master   adc,
    output logic              result_valid,
    output logic [CW-1:0]     result_ch,
    output logic [DATA_W-1:0] result_data,
    output logic              scan_done,
    output logic [N_CH-1:0]   alarm,
    output logic              overrun,
    output logic              err_timeout
);
    localparam int unsigned PW = $clog2(PERIOD);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] PerLast = PW'(PERIOD - 1);
    localparam logic [TW-1:0] TmoMax  = TW'(TIMEOUT);

    typedef enum logic [2:0] {StIdle, StArb, StIssue, StWait, StStore} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     per_cnt_q, per_cnt_d;
    logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic              scan_pend_q, scan_pend_d;
    logic              scan_act_q, scan_act_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [CW-1:0]     ch_q, ch_d;
    logic              owner_host_q, owner_host_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              adc_start_q, adc_start_d;
    logic              host_ack_q, host_ack_d;
    logic [DATA_W-1:0] host_data_q, host_data_d;
    logic              result_valid_q, result_valid_d;
    logic [CW-1:0]     result_ch_q, result_ch_d;
    logic [DATA_W-1:0] result_data_q, result_data_d;
    logic              scan_done_q, scan_done_d;
    logic [N_CH-1:0]   alarm_q, alarm_d;
    logic              overrun_q, overrun_d;
    logic              err_timeout_q, err_timeout_d;
    logic              wrap;
    logic              scan_start;
    logic [CW-1:0]     low_ch;

    // Lowest pending channel of the current scan.
    always_comb begin
        low_ch = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (mask_q[i]) low_ch = CW'(i);
        end
    end

    assign wrap = (per_cnt_q == PerLast);

    always_comb begin
        state_d        = state_q;
        per_cnt_d      = wrap ? '0 : per_cnt_q + 1'b1;
        tmo_cnt_d      = tmo_cnt_q;
        scan_pend_d    = scan_pend_q;
        scan_act_d     = scan_act_q;
        mask_d         = mask_q;
        ch_d           = ch_q;
        owner_host_d   = owner_host_q;
        data_d         = data_q;
        adc_start_d    = 1'b0;
        host_ack_d     = 1'b0;
        host_data_d    = host_data_q;
        result_valid_d = 1'b0;
        result_ch_d    = result_ch_q;
        result_data_d  = result_data_q;
        scan_done_d    = 1'b0;
        alarm_d        = alarm_q;
        overrun_d      = overrun_q;
        err_timeout_d  = err_timeout_q;
        scan_start     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (scan_pend_q && !scan_act_q) begin
                    scan_start  = 1'b1;
                    mask_d      = ch_en;
                    scan_pend_d = 1'b0;
                    scan_act_d  = 1'b1;
                end
                if (host_req || scan_pend_q || scan_act_q) state_d = StArb;
            end
            StArb: begin
                // The request that was just acked may still be high this cycle.
                if (host_req && !host_ack_q) begin
                    owner_host_d = 1'b1;
                    ch_d         = host_ch;
                    state_d      = StIssue;
                end else if (scan_act_q && (mask_q != '0)) begin
                    owner_host_d = 1'b0;
                    ch_d         = low_ch;
                    state_d      = StIssue;
                end else begin
                    if (scan_act_q) begin
                        scan_done_d = 1'b1;
                        scan_act_d  = 1'b0;
                    end
                    state_d = StIdle;
                end
            end
            StIssue: begin
                tmo_cnt_d = '0;
                if (!adc.adc_busy) begin
                    adc_start_d = 1'b1;
                    state_d     = StWait;
                end
            end
            StWait: begin
                if (adc.adc_done) begin
                    data_d  = adc.adc_data;
                    state_d = StStore;
                end else if (tmo_cnt_q == TmoMax) begin
                    err_timeout_d = 1'b1;
                    state_d       = StArb;
                    if (owner_host_q) begin
                        host_ack_d  = 1'b1;
                        host_data_d = '0;
                    end else begin
                        mask_d[ch_q] = 1'b0;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            StStore: begin
                state_d = StArb;
                if (owner_host_q) begin
                    host_ack_d  = 1'b1;
                    host_data_d = data_q;
                end else begin
                    result_valid_d = 1'b1;
                    result_ch_d    = ch_q;
                    result_data_d  = data_q;
                    mask_d[ch_q]   = 1'b0;
                end
                // Set wins when the thresholds overlap.
                if (data_q > alarm_hi) begin
                    alarm_d[ch_q] = 1'b1;
                end else if (data_q < alarm_lo) begin
                    alarm_d[ch_q] = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        // A scan consumed on the wrap cycle does not count as overrun.
        if (wrap) begin
            scan_pend_d = 1'b1;
            if (scan_pend_q && !scan_start) overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            per_cnt_q      <= '0;
            tmo_cnt_q      <= '0;
            scan_pend_q    <= 1'b0;
            scan_act_q     <= 1'b0;
            mask_q         <= '0;
            ch_q           <= '0;
            owner_host_q   <= 1'b0;
            data_q         <= '0;
            adc_start_q    <= 1'b0;
            host_ack_q     <= 1'b0;
            host_data_q    <= '0;
            result_valid_q <= 1'b0;
            result_ch_q    <= '0;
            result_data_q  <= '0;
            scan_done_q    <= 1'b0;
            alarm_q        <= '0;
            overrun_q      <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            per_cnt_q      <= per_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            scan_pend_q    <= scan_pend_d;
            scan_act_q     <= scan_act_d;
            mask_q         <= mask_d;
            ch_q           <= ch_d;
            owner_host_q   <= owner_host_d;
            data_q         <= data_d;
            adc_start_q    <= adc_start_d;
            host_ack_q     <= host_ack_d;
            host_data_q    <= host_data_d;
            result_valid_q <= result_valid_d;
            result_ch_q    <= result_ch_d;
            result_data_q  <= result_data_d;
            scan_done_q    <= scan_done_d;
            alarm_q        <= alarm_d;
            overrun_q      <= overrun_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

    assign adc.adc_start = adc_start_q;
    assign adc.adc_ch    = ch_q;
    assign adc.adc_sgl   = 1'b1;
    assign host_ack      = host_ack_q;
    assign host_data     = host_data_q;
    assign result_valid  = result_valid_q;
    assign result_ch     = result_ch_q;
    assign result_data   = result_data_q;
    assign scan_done     = scan_done_q;
    assign alarm         = alarm_q;
    assign overrun       = overrun_q;
    assign err_timeout   = err_timeout_q;
endmodule

// File: tb/tb_mcp_scan_ctrl.sv
// Directed bench for mcp_scan_ctrl: scan order, host arbitration, alarm hysteresis,
// timeout, empty scans / overrun and mid-conversion reset.
module tb_mcp_scan_ctrl;
    localparam int KStart = 1;
    localparam int KDone  = 2;
    localparam int KRes   = 3;
    localparam int KHost  = 4;
    localparam int KScan  = 5;

    typedef struct {
        int kind;
        int ch;
        int data;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ch_en = '0;
    logic [9:0] alarm_hi = 10'd1023;
    logic [9:0] alarm_lo = 10'd0;
    logic       host_req = 1'b0;
    logic [2:0] host_ch = '0;
    logic       host_ack;
    logic [9:0] host_data;
    logic       result_valid;
    logic [2:0] result_ch;
    logic [9:0] result_data;
    logic       scan_done;
    logic [7:0] alarm;
    logic       overrun;
    logic       err_timeout;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc;
    ev_t  log_q[$];
    logic mute = 1'b0;
    int   ret_table [8];
    int   m_cnt;
    logic [2:0] m_ch;

    mcp_scan_ctrl_if #(.CW(3), .DATA_W(10)) adc_if ();

    mcp_scan_ctrl #(
        .N_CH(8), .DATA_W(10), .PERIOD(100), .TIMEOUT(255)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .alarm_hi(alarm_hi), .alarm_lo(alarm_lo),
        .host_req(host_req), .host_ch(host_ch), .host_ack(host_ack), .host_data(host_data),
        .adc(adc_if), .result_valid(result_valid), .result_ch(result_ch),
        .result_data(result_data), .scan_done(scan_done), .alarm(alarm), .overrun(overrun),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // ADC engine: done 4 cycles after accepting a start, returns ret_table[ch].
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_if.adc_busy <= 1'b0;
            adc_if.adc_done <= 1'b0;
            adc_if.adc_data <= '0;
            m_cnt <= 0;
            m_ch  <= '0;
        end else begin
            adc_if.adc_done <= 1'b0;
            if (adc_if.adc_start && !mute) begin
                adc_if.adc_busy <= 1'b1;
                m_cnt <= 4;
                m_ch  <= adc_if.adc_ch;
            end else if (adc_if.adc_busy) begin
                if (m_cnt == 1) begin
                    adc_if.adc_busy <= 1'b0;
                    adc_if.adc_done <= 1'b1;
                    adc_if.adc_data <= 10'(ret_table[m_ch]);
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (adc_if.adc_start) log_q.push_back('{KStart, int'(adc_if.adc_ch), 0, cyc});
            if (adc_if.adc_done)  log_q.push_back('{KDone, 0, int'(adc_if.adc_data), cyc});
            if (result_valid) log_q.push_back('{KRes, int'(result_ch), int'(result_data), cyc});
            if (host_ack)     log_q.push_back('{KHost, 0, int'(host_data), cyc});
            if (scan_done)    log_q.push_back('{KScan, 0, 0, cyc});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int nxt(input int kind, input int from);
        for (int i = from; i < log_q.size(); i++) begin
            if (log_q[i].kind == kind) return i;
        end
        return -1;
    endfunction

    function automatic ev_t at(input int idx);
        ev_t e;
        e = '{-1, -1, -1, -1};
        if (idx >= 0 && idx < log_q.size()) e = log_q[idx];
        return e;
    endfunction

    task automatic run_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_event(input string tag, input int kind, input int budget,
                              output int idx);
        int from;
        from = log_q.size();
        idx  = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            idx = nxt(kind, from);
            if (idx >= 0) break;
        end
        check(tag, idx >= 0, 1);
    endtask

    task automatic host_read(input string tag, input logic [2:0] ch, output logic [9:0] d);
        bit got;
        got      = 1'b0;
        host_req = 1'b1;
        host_ch  = ch;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (host_ack) begin
                got = 1'b1;
                break;
            end
        end
        host_req = 1'b0;
        d        = host_data;
        check(tag, got, 1);
    endtask

    initial begin
        ev_t e, e2;
        int i, j, k, mark, s;
        logic [9:0] d;
        bit found;

        for (int c = 0; c < 8; c++) ret_table[c] = c * 100;
        ch_en = 8'h05;
        repeat (3) @(posedge clk);
        #1;
        check("rst_host_ack", host_ack, 0);
        check("rst_adc_start", adc_if.adc_start, 0);
        check("rst_adc_sgl", adc_if.adc_sgl, 1);
        check("rst_alarm", alarm, 0);
        check("rst_sticky", {overrun, err_timeout, scan_done, result_valid}, 0);
        rst_n = 1'b1;

        // Scan of ch0 and ch2, repeated every period.
        run_until(290);
        i = nxt(KStart, 0);
        e = at(i);
        check("t1_first_start_cyc", e.cyc, 103);
        check("t1_first_start_ch", e.ch, 0);
        i = nxt(KRes, 0);
        e = at(i);
        check("t1_res0_ch", e.ch, 0);
        check("t1_res0_data", e.data, 0);
        check("t1_res0_cyc", e.cyc, 110);
        e2 = at(nxt(KDone, 0));
        check("t1_done_to_result", e.cyc - e2.cyc, 2);
        j = nxt(KRes, i + 1);
        e = at(j);
        check("t1_res1_ch", e.ch, 2);
        check("t1_res1_data", e.data, 200);
        k = nxt(KScan, 0);
        e = at(k);
        check("t1_scan_done_cyc", e.cyc, 120);
        check("t1_scan_done_after_res", k > j, 1);
        e = at(nxt(KStart, k));
        check("t1_second_scan_start", e.cyc, 203);

        // Empty scan: scan_done two cycles after the wrap, no conversion.
        ch_en = 8'h00;
        mark  = log_q.size();
        run_until(399);
        e = at(nxt(KScan, mark));
        check("t5_empty_scan_done_cyc", e.cyc, 302);
        check("t5_no_adc_start", nxt(KStart, mark), -1);

        // Host read of ch3 lands between the ch0 and ch1 scan slots.
        ch_en = 8'h03;
        mark  = log_q.size();
        wait_event("t2_wait_start", KStart, 20, i);
        host_read("t2_host_ack_seen", 3'd3, d);
        check("t2_host_data", d, 300);
        wait_event("t2_wait_scan_done", KScan, 60, k);
        i = nxt(KRes, mark);
        j = nxt(KHost, mark);
        e = at(i);
        check("t2_first_res_ch", e.ch, 0);
        check("t2_host_after_res0", j > i, 1);
        e = at(nxt(KRes, i + 1));
        check("t2_second_res_ch", e.ch, 1);
        check("t2_second_res_data", e.data, 100);
        check("t2_res1_after_host", nxt(KRes, i + 1) > j, 1);
        check("t2_single_host_ack", nxt(KHost, j + 1), -1);

        // Alarm hysteresis on ch1 through host reads.
        ch_en    = 8'h00;
        alarm_hi = 10'd500;
        alarm_lo = 10'd400;
        ret_table[1] = 450;
        host_read("t3_ack_a", 3'd1, d);
        check("t3_data_450", d, 450);
        check("t3_alarm_450_a", alarm[1], 0);
        ret_table[1] = 510;
        host_read("t3_ack_b", 3'd1, d);
        check("t3_alarm_510", alarm[1], 1);
        ret_table[1] = 450;
        host_read("t3_ack_c", 3'd1, d);
        check("t3_alarm_450_b", alarm[1], 1);
        ret_table[1] = 390;
        host_read("t3_ack_d", 3'd1, d);
        check("t3_alarm_390", alarm[1], 0);
        check("t3_other_alarms", alarm & 8'hFD, 0);

        // Silent ADC: each slot times out and the scan moves on.
        check("t4_err_timeout_clear", err_timeout, 0);
        mute  = 1'b1;
        ch_en = 8'h06;
        mark  = log_q.size();
        wait_event("t4_wait_start", KStart, 200, i);
        e = at(i);
        s = e.cyc;
        check("t4_start_after_wrap", s % 100, 3);
        check("t4_start_ch", e.ch, 1);
        found = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #1;
            if (err_timeout) begin
                found = 1'b1;
                break;
            end
        end
        check("t4_timeout_seen", found, 1);
        check("t4_timeout_cyc", cyc - s, 256);
        wait_event("t4_wait_next_start", KStart, 20, j);
        e = at(j);
        check("t4_next_ch", e.ch, 2);
        check("t4_next_start_cyc", e.cyc - s, 258);
        check("t4_overrun", overrun, 1);
        check("t4_no_result", nxt(KRes, mark), -1);

        // Reset while waiting on a conversion, then a full period before the next scan.
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_err_timeout", err_timeout, 0);
        check("t6_overrun", overrun, 0);
        check("t6_host_data", host_data, 0);
        check("t6_adc_start", adc_if.adc_start, 0);
        check("t6_adc_ch", adc_if.adc_ch, 0);
        check("t6_adc_sgl", adc_if.adc_sgl, 1);
        log_q.delete();
        mute  = 1'b0;
        ch_en = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_until(99);
        check("t6_quiet_first_period", log_q.size(), 0);
        wait_event("t6_wait_start", KStart, 20, i);
        e = at(i);
        check("t6_first_start_cyc", e.cyc, 103);
        wait_event("t6_wait_result", KRes, 20, j);
        e = at(j);
        check("t6_result_cyc", e.cyc, 110);
        check("t6_result_ch", e.ch, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
